mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 157 +++++++++++++++
 tb/tb_mem_io_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Byte-wide CPU memory responder: RAM, rx/tx byte I/O, stop flag.
// Define CYCLE_COUNTER_EN to add a 32-bit cycle counter readable at 0x30004..7.
module mem_io_responder #(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        cpu_rdy,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_stop
);
    localparam int PW = $clog2(TX_DEPTH);

    logic [7:0]    ram [2**RAM_AW];
    logic [7:0]    fifo [TX_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [7:0]    mem_din_q, mem_din_d;
    logic          prog_stop_q, prog_stop_d;

    logic [17:0] a;
    logic        io_sel, ram_sel, io_data, io_stop, io_cnt;
    logic        fifo_full, rd_ok, wr_ok, push, pop;
    logic [7:0]  push_data, io_rdata;
    logic        unused_hi;

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] snap_q, snap_d;
`endif

    assign a         = mem_a[17:0];
    assign unused_hi = ^mem_a[31:18];
    assign io_sel    = a[17:16] == 2'b11;
    assign ram_sel   = !io_sel && ({1'b0, a} < (19'd1 << RAM_AW));
    assign io_data   = io_sel && a[15:0] == 16'h0000;
    assign io_stop   = io_sel && a[15:0] == 16'h0004;
    assign io_cnt    = io_sel && a[15:2] == 14'd1;
    assign fifo_full = count_q == (PW+1)'(TX_DEPTH);

    assign mem_din   = mem_din_q;
    assign prog_stop = prog_stop_q;
    assign tx_valid  = count_q != '0;
    assign tx_data   = fifo[rd_ptr_q];

    always_comb begin
        cpu_rdy = 1'b1;
        if (!rst_in) begin
            // full check uses the registered count, so a same-cycle pop does not help
            if (io_sel && mem_wr && fifo_full)
                cpu_rdy = 1'b0;
            if (io_data && !mem_wr && !rx_valid)
                cpu_rdy = 1'b0;
        end
        rd_ok    = cpu_rdy && !mem_wr && !rst_in;
        wr_ok    = cpu_rdy && mem_wr && !rst_in;
        rx_ready = rd_ok && io_data;

        push      = 1'b0;
        push_data = mem_dout;
        if (wr_ok && io_data && mem_dout != 8'h00)
            push = 1'b1;
        if (wr_ok && io_stop) begin
            push      = 1'b1;
            push_data = 8'h00;
        end
        pop = tx_valid && tx_ready;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;

        prog_stop_d = prog_stop_q || (wr_ok && io_stop);

        io_rdata = 8'h00;
        if (io_data)
            io_rdata = rx_data;
`ifdef CYCLE_COUNTER_EN
        cyc_d  = cyc_q + 32'd1;
        snap_d = snap_q;
        if (rd_ok && io_cnt && a[1:0] == 2'd0)
            snap_d = cyc_q;
        if (io_cnt) begin
            case (a[1:0])
                2'd0:    io_rdata = cyc_q[7:0];
                2'd1:    io_rdata = snap_q[15:8];
                2'd2:    io_rdata = snap_q[23:16];
                default: io_rdata = snap_q[31:24];
            endcase
        end
`else
        if (io_cnt)
            io_rdata = 8'h00;
`endif

        mem_din_d = mem_din_q;
        if (rd_ok) begin
            if (io_sel)
                mem_din_d = io_rdata;
            else if (ram_sel)
                mem_din_d = ram[a[RAM_AW-1:0]];
            else
                mem_din_d = 8'h00;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_din_q   <= 8'h00;
            prog_stop_q <= 1'b0;
`ifdef CYCLE_COUNTER_EN
            cyc_q       <= 32'd0;
            snap_q      <= 32'd0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_din_q   <= mem_din_d;
            prog_stop_q <= prog_stop_d;
`ifdef CYCLE_COUNTER_EN
            cyc_q       <= cyc_d;
            snap_q      <= snap_d;
`endif
        end
    end

    // storage arrays keep their contents across reset
    always_ff @(posedge clk_in) begin
        if (wr_ok && ram_sel)
            ram[a[RAM_AW-1:0]] <= mem_dout;
        if (push)
            fifo[wr_ptr_q] <= push_data;
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: directed vectors, queued
// expectations for read data and tx bytes, checked by a negedge monitor.
`timescale 1ns/1ps
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        cpu_rdy;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        prog_stop;

    int n_cmp = 0;
    int n_bad = 0;
    int stall_cnt = 0;
    int rx_pulses = 0;
    logic [7:0] exp_rd[$];
    logic [7:0] exp_tx[$];
    logic chk_rd = 1'b0;
    logic rd_due = 1'b0;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
        .mem_din(mem_din), .cpu_rdy(cpu_rdy),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .prog_stop(prog_stop)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name, string why);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", name, why);
    endtask

    // monitor: compares DUT outputs against queued expectations
    initial forever begin
        @(negedge clk_in);
        if (rd_due) begin
            rd_due = 1'b0;
            if (exp_rd.size() == 0)
                fail("mem_din", "read data with nothing expected");
            else
                check("mem_din", mem_din, exp_rd.pop_front());
        end
        if (!rst_in && chk_rd && cpu_rdy && !mem_wr)
            rd_due = 1'b1;
        if (!rst_in && tx_valid && tx_ready) begin
            if (exp_tx.size() == 0)
                fail("tx_data", "tx byte with nothing expected");
            else
                check("tx_data", tx_data, exp_tx.pop_front());
        end
        if (rx_ready)
            rx_pulses++;
        if (!cpu_rdy)
            stall_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        mem_a    = 32'h0002_0000;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
        chk_rd   = 1'b0;
    endtask

    task automatic wait_rdy(string name);
        int n;
        n = 0;
        @(negedge clk_in);
        while (!cpu_rdy && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        if (!cpu_rdy)
            fail(name, "cpu_rdy stuck low");
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(logic [31:0] ad, logic [7:0] d);
        mem_a    = ad;
        mem_wr   = 1'b1;
        mem_dout = d;
        wait_rdy("wr_rdy");
        idle();
    endtask

    task automatic rd(logic [31:0] ad, logic [7:0] e);
        exp_rd.push_back(e);
        mem_a  = ad;
        mem_wr = 1'b0;
        chk_rd = 1'b1;
        wait_rdy("rd_rdy");
        idle();
    endtask

    initial begin
        idle();
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        mem_a    = 32'h0003_0000;

        // reset state, with an rx read presented that must not stall
        #12;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_cpu_rdy", cpu_rdy, 1);
        check("rst_prog_stop", prog_stop, 0);
        check("rst_mem_din", mem_din, 8'h00);
        check("rst_rx_ready", rx_ready, 0);
        idle();
        @(negedge clk_in) rst_in = 1'b0;
        @(posedge clk_in);
        #1;

        // RAM write/read, top boundary, unmapped region
        stall_cnt = 0;
        wr(32'h0000_0100, 8'hA5);
        rd(32'h0000_0100, 8'hA5);
        wr(32'h0001_FFFF, 8'h5A);
        rd(32'h0001_FFFF, 8'h5A);
        wr(32'h0002_0100, 8'h77);
        rd(32'h0002_0100, 8'h00);
        rd(32'h0000_0100, 8'hA5);
        @(negedge clk_in);
        check("ram_no_stall", stall_cnt, 0);
        @(posedge clk_in);
        #1;

        // zero byte dropped, stop pushes 0x00 and sets prog_stop
        wr(32'h0003_0000, 8'h00);
        wr(32'h0003_0004, 8'h07);
        exp_tx.push_back(8'h00);
        @(negedge clk_in);
        check("stop_flag", prog_stop, 1);
        check("stop_tx_valid", tx_valid, 1);
        @(posedge clk_in);
        #1 tx_ready = 1'b1;
        @(posedge clk_in);
        #1 tx_ready = 1'b0;
        @(negedge clk_in);
        check("one_byte_only", tx_valid, 0);
        check("stop_sticky", prog_stop, 1);
        @(posedge clk_in);
        #1;

        // fill FIFO, ninth write stalls until a pop frees space
        for (int i = 0; i < 8; i++) begin
            wr(32'h0003_0000, 8'h41);
            exp_tx.push_back(8'h41);
        end
        mem_a     = 32'h0003_0000;
        mem_wr    = 1'b1;
        mem_dout  = 8'h41;
        stall_cnt = 0;
        repeat (3) @(posedge clk_in);
        #1;
        check("full_stall", stall_cnt, 3);
        tx_ready = 1'b1;
        @(posedge clk_in);
        #1 tx_ready = 1'b0;
        @(negedge clk_in);
        check("after_pop_rdy", cpu_rdy, 1);
        exp_tx.push_back(8'h41);
        @(posedge clk_in);
        #1 idle();
        @(negedge clk_in);
        check("ninth_done_rdy", cpu_rdy, 1);
        check("ninth_tx_valid", tx_valid, 1);

        // full again: push with a simultaneous pop still stalls; then reset mid-stall
        @(posedge clk_in);
        #1;
        mem_a    = 32'h0003_0000;
        mem_wr   = 1'b1;
        mem_dout = 8'h41;
        tx_ready = 1'b1;
        @(negedge clk_in);
        check("push_pop_full_stall", cpu_rdy, 0);
        #2 rst_in = 1'b1;
        #1;
        check("arst_tx_valid", tx_valid, 0);
        check("arst_cpu_rdy", cpu_rdy, 1);
        check("arst_prog_stop", prog_stop, 0);
        exp_tx.delete();
        tx_ready = 1'b0;
        idle();
        @(negedge clk_in) rst_in = 1'b0;
        @(negedge clk_in);
        check("abort_no_push", tx_valid, 0);
        @(posedge clk_in);
        #1;

        // rx read stalls 5 cycles then consumes one byte
        stall_cnt = 0;
        rx_pulses = 0;
        rx_data   = 8'h3C;
        exp_rd.push_back(8'h3C);
        mem_a  = 32'h0003_0000;
        mem_wr = 1'b0;
        chk_rd = 1'b1;
        repeat (5) @(posedge clk_in);
        #1 rx_valid = 1'b1;
        @(posedge clk_in);
        #1;
        rx_valid = 1'b0;
        idle();
        @(negedge clk_in);
        check("rx_stall_cycles", stall_cnt, 5);
        check("rx_pulse_once", rx_pulses, 1);
        @(posedge clk_in);
        #1;
        rx_valid = 1'b1;
        rx_data  = 8'h81;
        rd(32'h0003_0000, 8'h81);
        rx_valid = 1'b0;
        @(negedge clk_in);
        check("rx_pulse_twice", rx_pulses, 2);
        @(posedge clk_in);
        #1;

        // unused I/O addresses
        wr(32'h0003_0008, 8'h55);
        @(negedge clk_in);
        check("io_unused_wr", tx_valid, 0);
        @(posedge clk_in);
        #1;
        rd(32'h0003_0010, 8'h00);

        // cycle counter snapshot at counter 0x123
        rst_in = 1'b1;
        @(negedge clk_in) rst_in = 1'b0;
        repeat (291) @(posedge clk_in);
        #1;
`ifdef CYCLE_COUNTER_EN
        rd(32'h0003_0004, 8'h23);
        rd(32'h0003_0005, 8'h01);
`else
        rd(32'h0003_0004, 8'h00);
        rd(32'h0003_0005, 8'h00);
`endif
        repeat (3) @(posedge clk_in);
        #1;
        check("rd_queue_drained", exp_rd.size(), 0);
        check("tx_queue_drained", exp_tx.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
